// File: rtl/npu_sparse_pkg.sv
// Shared types and size defaults for the sparse chunk packer.
// Sizing helpers live here so the top and the compactor agree on widths.
package npu_sparse_pkg;

  localparam int BUS_SIZE_DEF       = 32;
  localparam int WR_DAT_CYC_NUM_DEF = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t [BUS_SIZE_DEF-1:0] beat_t;

  // A single-beat chunk still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WR_DAT_CYC_NUM_DEF);
  localparam int NNZ_W_DEF = $clog2(BUS_SIZE_DEF * WR_DAT_CYC_NUM_DEF) + 1;

endpackage

// File: rtl/beat_compactor.sv
// Combinational compaction of one dense beat into a sparsemap and
// left-packed nonzero bytes (ascending order, unused slots zero).
module beat_compactor
  import npu_sparse_pkg::*;
#(
  parameter int BUS_SIZE = BUS_SIZE_DEF
) (
  input  logic [BUS_SIZE*8-1:0] dense_data,
  output logic [BUS_SIZE-1:0]   sparsemap,
  output logic [BUS_SIZE*8-1:0] packed_data
);

  localparam int IDX_W = $clog2(BUS_SIZE) + 1;

  byte_t            in_bytes [BUS_SIZE];
  logic [IDX_W-1:0] rank     [BUS_SIZE];

  genvar gi;
  generate
    for (gi = 0; gi < BUS_SIZE; gi++) begin : g_byte
      assign in_bytes[gi]  = dense_data[gi*8 +: 8];
      assign sparsemap[gi] = |in_bytes[gi];
    end
  endgenerate

  // rank[i] = number of nonzero bytes below byte i = its destination slot.
  always_comb begin : p_rank
    logic [IDX_W-1:0] run;
    run = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      rank[i] = run;
      run     = run + IDX_W'(sparsemap[i]);
    end
  end

  generate
    for (gi = 0; gi < BUS_SIZE; gi++) begin : g_slot
      byte_t slot_val;
      // Only bytes at or above this slot index can land here.
      always_comb begin
        slot_val = '0;
        for (int i = gi; i < BUS_SIZE; i++) begin
          if (sparsemap[i] && (rank[i] == IDX_W'(gi))) begin
            slot_val = slot_val | in_bytes[i];
          end
        end
      end
      assign packed_data[gi*8 +: 8] = slot_val;
    end
  endgenerate

endmodule

// File: rtl/sparse_chunk_packer.sv
// Dense-to-sparse beat packer feeding a double-buffered chunk store.
// Optional macro SPARSE_PACK_NNZ_COUNT_EN adds per-chunk nonzero count port.
module sparse_chunk_packer
  import npu_sparse_pkg::*;
#(
  parameter int  BUS_SIZE       = BUS_SIZE_DEF,
  parameter int  WR_DAT_CYC_NUM = WR_DAT_CYC_NUM_DEF,
  localparam int CNT_W          = cnt_width(WR_DAT_CYC_NUM)
`ifdef SPARSE_PACK_NNZ_COUNT_EN
  , localparam int NNZ_W        = $clog2(BUS_SIZE * WR_DAT_CYC_NUM) + 1
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dense_valid_i,
  output logic                  dense_ready_o,
  input  logic [BUS_SIZE*8-1:0] dense_data_i,
  output logic [BUS_SIZE-1:0]   sparsemap_o,
  output logic [BUS_SIZE*8-1:0] nonzero_data_o,
  output logic                  chunk_wr_valid_o,
  output logic [CNT_W-1:0]      chunk_wr_count_o,
  output logic                  chunk_wr_sel_o,
  output logic                  chunk_rd_sel_o,
  output logic                  chunk_full_o,
  input  logic                  chunk_release_i
`ifdef SPARSE_PACK_NNZ_COUNT_EN
  , output logic [NNZ_W-1:0]    chunk_nnz_o
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WR_DAT_CYC_NUM - 1);

  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  wr_bank_reg, wr_bank_next;
  logic                  rd_bank_reg, rd_bank_next;
  logic [1:0]            busy_reg, busy_next;
  logic [1:0]            full_reg, full_next;

  logic                  wr_valid_reg, wr_valid_next;
  logic [CNT_W-1:0]      wr_count_reg, wr_count_next;
  logic                  wr_sel_reg, wr_sel_next;
  logic [BUS_SIZE-1:0]   map_reg, map_next;
  logic [BUS_SIZE*8-1:0] data_reg, data_next;

  logic [BUS_SIZE-1:0]   beat_map;
  logic [BUS_SIZE*8-1:0] beat_data;
  logic                  accept, last_beat, release_ok, chunk_done;

  beat_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
    .dense_data  (dense_data_i),
    .sparsemap   (beat_map),
    .packed_data (beat_data)
  );

  // Ready looks only at registered bank state, so it never waits on valid.
  assign dense_ready_o = rst_i & ~busy_reg[wr_bank_reg];
  assign accept        = dense_valid_i & dense_ready_o;
  assign last_beat     = (cnt_reg == LAST_IDX);
  assign release_ok    = chunk_release_i & full_reg[rd_bank_reg];
  assign chunk_done    = wr_valid_reg & (wr_count_reg == LAST_IDX);

  always_comb begin
    cnt_next      = cnt_reg;
    wr_bank_next  = wr_bank_reg;
    rd_bank_next  = rd_bank_reg;
    busy_next     = busy_reg;
    full_next     = full_reg;
    wr_valid_next = accept;
    wr_count_next = wr_count_reg;
    wr_sel_next   = wr_sel_reg;
    map_next      = map_reg;
    data_next     = data_reg;

    if (release_ok) begin
      busy_next[rd_bank_reg] = 1'b0;
      full_next[rd_bank_reg] = 1'b0;
      rd_bank_next           = ~rd_bank_reg;
    end

    // The bank becomes readable once its final beat has been strobed out.
    if (chunk_done) begin
      full_next[wr_sel_reg] = 1'b1;
    end

    if (accept) begin
      wr_count_next = cnt_reg;
      wr_sel_next   = wr_bank_reg;
      map_next      = beat_map;
      data_next     = beat_data;
      if (last_beat) begin
        cnt_next               = '0;
        busy_next[wr_bank_reg] = 1'b1;
        wr_bank_next           = ~wr_bank_reg;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg      <= '0;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      busy_reg     <= '0;
      full_reg     <= '0;
      wr_valid_reg <= 1'b0;
      wr_count_reg <= '0;
      wr_sel_reg   <= 1'b0;
      map_reg      <= '0;
      data_reg     <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      wr_bank_reg  <= wr_bank_next;
      rd_bank_reg  <= rd_bank_next;
      busy_reg     <= busy_next;
      full_reg     <= full_next;
      wr_valid_reg <= wr_valid_next;
      wr_count_reg <= wr_count_next;
      wr_sel_reg   <= wr_sel_next;
      map_reg      <= map_next;
      data_reg     <= data_next;
    end
  end

  assign sparsemap_o      = map_reg;
  assign nonzero_data_o   = data_reg;
  assign chunk_wr_valid_o = wr_valid_reg;
  assign chunk_wr_count_o = wr_count_reg;
  assign chunk_wr_sel_o   = wr_sel_reg;
  assign chunk_rd_sel_o   = rd_bank_reg;
  assign chunk_full_o     = full_reg[rd_bank_reg];

`ifdef SPARSE_PACK_NNZ_COUNT_EN
  logic [NNZ_W-1:0] nnz_acc_reg, nnz_acc_next;
  logic [NNZ_W-1:0] nnz_out_reg, nnz_out_next;
  logic [NNZ_W-1:0] beat_nnz;

  // Counted on the strobed beat so the total lands together with full[].
  assign beat_nnz = NNZ_W'($countones(map_reg));

  always_comb begin
    nnz_acc_next = nnz_acc_reg;
    nnz_out_next = nnz_out_reg;
    if (wr_valid_reg) begin
      if (chunk_done) begin
        nnz_out_next = nnz_acc_reg + beat_nnz;
        nnz_acc_next = '0;
      end else begin
        nnz_acc_next = nnz_acc_reg + beat_nnz;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      nnz_acc_reg <= '0;
      nnz_out_reg <= '0;
    end else begin
      nnz_acc_reg <= nnz_acc_next;
      nnz_out_reg <= nnz_out_next;
    end
  end

  assign chunk_nnz_o = nnz_out_reg;
`else
  // No per-chunk nonzero accounting in this build.
`endif

endmodule

// File: doc/sparse_chunk_packer.md
Name: sparse_chunk_packer

Overview:
- Upstream feeder of the compute unit's filter/IFM chunk double-buffers.
- Accepts a dense byte stream, BUS_SIZE bytes per beat, and emits per-beat sparsemap plus left-compacted nonzero bytes.
- Sequences chunk write count and write-bank select, and tracks which bank holds a complete chunk ready for compute.
- Back-pressures the stream when the target bank has not yet been released by the consumer.

Parameters:
- BUS_SIZE, 32, bytes per input beat and bits per sparsemap beat.
- WR_DAT_CYC_NUM, 4, beats per chunk.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- dense_valid_i  in  1  input beat valid.
- dense_ready_o  out  1  beat accepted when valid&ready.
- dense_data_i  in  BUS_SIZE x 8  dense bytes; byte 0 is lowest.
- sparsemap_o  out  BUS_SIZE  bit i = (byte i != 0).
- nonzero_data_o  out  BUS_SIZE x 8  nonzero bytes packed from slot 0, upper slots 0.
- chunk_wr_valid_o  out  1  write strobe to chunk buffer.
- chunk_wr_count_o  out  clog2(WR_DAT_CYC_NUM)  beat index within chunk.
- chunk_wr_sel_o  out  1  bank being written.
- chunk_rd_sel_o  out  1  bank the consumer must read.
- chunk_full_o  out  1  bank chunk_rd_sel_o holds a complete chunk.
- chunk_release_i  in  1  one-cycle pulse: consumer finished bank chunk_rd_sel_o.

Behaviour:
- Reset (rst_i low, async): all outputs 0, including dense_ready_o. Beat counter = 0, wr bank = 0, rd bank = 0, busy[1:0] = 0, full[1:0] = 0.
- Ready rule: dense_ready_o = rst_i & !busy[wr bank]. It is combinational from registered state only and never depends on dense_valid_i.
- Accept: one beat per cycle max.
- Output latency: exactly 1 cycle. The cycle after an accept:
  - chunk_wr_valid_o = 1.
  - sparsemap_o and nonzero_data_o reflect that beat.
  - chunk_wr_count_o = beat index.
  - chunk_wr_sel_o = bank at accept time.
  - Otherwise chunk_wr_valid_o = 0; data outputs hold their last value.
- Compaction: nonzero bytes keep ascending order. Popcount k means slots 0..k-1 are valid and slots k..BUS_SIZE-1 = 8'h00. All-zero beat gives sparsemap 0 and data 0.
- Counter: increments on accept. On accept at WR_DAT_CYC_NUM-1:
  - counter wraps to 0;
  - busy[wr bank] is set;
  - wr bank toggles.
  - All take effect next cycle.
- Full: full[b] is set in the cycle the last beat's chunk_wr_valid_o is high, so it is visible one cycle later. chunk_full_o = full[rd bank].
- Release: chunk_release_i with chunk_full_o clears busy and full of rd bank, and toggles rd bank. chunk_release_i without chunk_full_o is ignored.
- Simultaneous events:
  - Last-beat accept and release of the other bank in the same cycle are both performed.
  - Same-bank collision is impossible: accept needs !busy[wr], release needs full[rd].
- Stall: with both banks busy, dense_ready_o = 0. It rises the cycle after the releasing pulse.
- Reset mid-chunk: partial chunk is discarded, no write strobe follows, and the counter restarts at 0.

Optional Feature:
- SPARSE_PACK_NNZ_COUNT_EN adds port chunk_nnz_o, width clog2(BUS_SIZE*WR_DAT_CYC_NUM)+1.
  - It holds the total nonzero-byte count of the most recently completed chunk.
  - It updates in the same cycle full[] is set and resets to 0.
- Without the macro: the port and its accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package npu_sparse_pkg: BUS_SIZE and WR_DAT_CYC_NUM defaults, byte_t, beat_t (BUS_SIZE x byte_t), and the count-width localparams.
- Sub-module beat_compactor: purely combinational prefix-sum compaction of one beat into sparsemap plus packed data. The top holds the counter, bank state, and output register.

Test Plan:
- Single chunk, BUS_SIZE=32, WR_DAT_CYC_NUM=4.
  - Stimulus: beat with bytes 3=8'h05, 10=8'h0A, 31=8'hFF, rest 0.
  - Response: sparsemap 0x80000408, data slots 0..2 = 05,0A,FF, slots 3..31 = 0, wr_valid one cycle after accept.
  - After 4 beats: count 0,1,2,3, wr_sel 0, chunk_full_o=1 the cycle after the 4th strobe.
- All-zero and all-nonzero beats:
  - All-zero gives sparsemap 0 and data 0.
  - Bytes 1..32 give sparsemap 0xFFFFFFFF and data identical to input.
- Double-buffer back-pressure:
  - Stimulus: stream 8 beats with no release.
  - Response: banks 0 then 1 fill, dense_ready_o = 0 from the cycle after the 8th accept, rd_sel 0.
  - Release pulse: rd_sel goes to 1, ready = 1 next cycle, next strobes use wr_sel 0.
- Release without full: pulse chunk_release_i after reset → no state change. Pulse in the same cycle as a last-beat accept on the other bank → both take effect.
- Reset mid-chunk: assert rst_i low after 2 beats → outputs 0 immediately. After deassert, the first strobe has count 0 and wr_sel 0.
- With SPARSE_PACK_NNZ_COUNT_EN: beats with 3,0,32,1 nonzeros → chunk_nnz_o = 36, aligned with the full[] update.
